// File: rtl/seg7_capture_if.sv
// Display pins observed by seg7_capture (an_n/seg_n/dp_n) and the decoded frame it publishes.
// master drives the pins and consumes the frame; slave is the capture block.
interface seg7_capture_if;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [15:0] hex_out;
  logic [3:0]  dp_out;
  logic [3:0]  blank_out;
  logic [3:0]  err_out;
  logic        frame_valid;
  logic        pattern_err;

  modport master (
    output an_n, seg_n, dp_n,
    input  hex_out, dp_out, blank_out, err_out, frame_valid, pattern_err
  );

  modport slave (
    input  an_n, seg_n, dp_n,
    output hex_out, dp_out, blank_out, err_out, frame_valid, pattern_err
  );
endinterface

// File: rtl/seg7_capture.sv
// Recovers hex value, DP, blank and glyph validity per digit from a scanned 4-digit 7-seg display.
// A digit is captured after SETTLE_CYCLES identical samples; one atomic frame is published once all four are captured.
module seg7_capture #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_capture_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SETTLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [3:0]       r_an_s1, r_an_s2;
  logic [6:0]       r_seg_s1, r_seg_s2;
  logic             r_dp_s1, r_dp_s2;
  logic [11:0]      r_s_prev;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_mask;
  logic [15:0]      r_sh_hex;
  logic [3:0]       r_sh_dp, r_sh_blank, r_sh_err;
  logic [15:0]      r_hex_out;
  logic [3:0]       r_dp_out, r_blank_out, r_err_out;
  logic             r_frame_valid, r_pattern_err;

  logic [11:0]      w_s;
  logic             w_stable;
  logic [3:0]       w_an_lo;
  logic             w_onehot;
  logic [1:0]       w_idx;
  logic [6:0]       w_lit;
  logic [3:0]       w_nib;
  logic             w_legal, w_blank;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_capture;
  logic             w_frame_due;
  logic [3:0]       w_mask_nxt;

  assign w_s      = {r_an_s2, r_dp_s2, r_seg_s2};
  assign w_stable = (w_s == r_s_prev);
  assign w_an_lo  = ~r_an_s2;
  assign w_onehot = (w_an_lo != 4'd0) && ((w_an_lo & (w_an_lo - 4'd1)) == 4'd0);
  assign w_lit    = ~r_seg_s2;

  always_comb begin
    w_idx = 2'd0;
    case (w_an_lo)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  // Lit-segment pattern {g,f,e,d,c,b,a} to hex value; all-dark is blank, not an error.
  always_comb begin
    w_nib   = 4'h0;
    w_legal = 1'b1;
    w_blank = 1'b0;
    case (w_lit)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      7'h00: w_blank = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Capture fires on the edge that moves the counter to SETTLE_CYCLES-1, i.e. the SETTLE_CYCLES-th identical sample.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (!w_onehot) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
        end
        ST_SETTLE: begin
          if (!w_stable) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_PRE) begin
            w_cnt_nxt   = CNT_LAST;
            w_capture   = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (!w_stable) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A capture in the publish cycle lands in the freshly cleared mask.
  assign w_frame_due = (r_mask == 4'hF);
  assign w_mask_nxt  = (w_frame_due ? 4'h0 : r_mask) | (w_capture ? (4'b0001 << w_idx) : 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_s1  <= '0;
      r_an_s2  <= '0;
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_dp_s1  <= 1'b0;
      r_dp_s2  <= 1'b0;
      r_s_prev <= '0;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
    end else begin
      r_an_s1  <= bus.an_n;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= bus.seg_n;
      r_seg_s2 <= r_seg_s1;
      r_dp_s1  <= bus.dp_n;
      r_dp_s2  <= r_dp_s1;
      r_s_prev <= w_s;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask        <= '0;
      r_sh_hex      <= '0;
      r_sh_dp       <= '0;
      r_sh_blank    <= '0;
      r_sh_err      <= '0;
      r_hex_out     <= '0;
      r_dp_out      <= '0;
      r_blank_out   <= '0;
      r_err_out     <= '0;
      r_frame_valid <= 1'b0;
      r_pattern_err <= 1'b0;
    end else begin
      r_mask        <= w_mask_nxt;
      r_frame_valid <= w_frame_due;
      r_pattern_err <= w_capture && !w_legal;
      if (w_frame_due) begin
        r_hex_out   <= r_sh_hex;
        r_dp_out    <= r_sh_dp;
        r_blank_out <= r_sh_blank;
        r_err_out   <= r_sh_err;
      end
      if (w_capture) begin
        r_sh_hex[{w_idx, 2'b00} +: 4] <= w_nib;
        r_sh_dp[w_idx]                <= ~r_dp_s2;
        r_sh_blank[w_idx]             <= w_blank;
        r_sh_err[w_idx]               <= ~w_legal;
      end
    end
  end

  assign bus.hex_out     = r_hex_out;
  assign bus.dp_out      = r_dp_out;
  assign bus.blank_out   = r_blank_out;
  assign bus.err_out     = r_err_out;
  assign bus.frame_valid = r_frame_valid;
  assign bus.pattern_err = r_pattern_err;
endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: table of full-frame scans plus hand sequences for glitches, IDLE, reset and latency.
module tb_seg7_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg7_capture_if bus();

  seg7_capture #(.SETTLE_CYCLES(16), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  typedef struct packed {
    logic [27:0] segs;   // digit i seg_n at [7i+6:7i]
    logic [3:0]  dpn;
    frame_t      exp;
    logic [7:0]  perr;
  } vec_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int frames   = 0;
  int perrs    = 0;
  int cyc      = 0;
  int fv_time  = 0;
  int fv_prev  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every published frame must match the next queued expectation.
  always @(negedge clk) begin
    frame_t e;
    cyc++;
    if (rst_n && bus.frame_valid) begin
      frames++;
      fv_prev = fv_time;
      fv_time = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame: frame_valid with empty queue, hex_out=0x%0h", bus.hex_out);
      end else begin
        e = exp_q.pop_front();
        chk("frame_hex", 32'(bus.hex_out), 32'(e.hex));
        chk("frame_dp", 32'(bus.dp_out), 32'(e.dp));
        chk("frame_blank", 32'(bus.blank_out), 32'(e.blank));
        chk("frame_err", 32'(bus.err_out), 32'(e.err));
      end
    end
    if (rst_n && bus.pattern_err) perrs++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive(input int idx, input logic [6:0] seg, input logic dpn, input int cycles);
    logic [3:0] one;
    one = 4'b0001 << idx;
    bus.an_n  = ~one;
    bus.seg_n = seg;
    bus.dp_n  = dpn;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    bus.an_n  = 4'hF;
    bus.seg_n = 7'h7F;
    bus.dp_n  = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_hex"}, 32'(bus.hex_out), 32'h0);
    chk({tag, "_dp"}, 32'(bus.dp_out), 32'h0);
    chk({tag, "_blank"}, 32'(bus.blank_out), 32'h0);
    chk({tag, "_err"}, 32'(bus.err_out), 32'h0);
  endtask

  vec_t vecs[7];

  initial begin
    int f0, p0, lat;
    frame_t ef;

    vecs[0] = '{segs: {7'h08, 7'h30, 7'h79, 7'h40}, dpn: 4'hF,
                exp: '{hex: 16'hA310, dp: 4'h0, blank: 4'h0, err: 4'h0}, perr: 8'd0};
    vecs[1] = '{segs: {7'h40, 7'h7F, 7'h40, 7'h40}, dpn: 4'b1011,
                exp: '{hex: 16'h0000, dp: 4'b0100, blank: 4'b0100, err: 4'h0}, perr: 8'd0};
    vecs[2] = '{segs: {7'h40, 7'h40, 7'h7E, 7'h40}, dpn: 4'hF,
                exp: '{hex: 16'h0000, dp: 4'h0, blank: 4'h0, err: 4'b0010}, perr: 8'd1};
    vecs[3] = '{segs: {7'h00, 7'h00, 7'h00, 7'h00}, dpn: 4'hF,
                exp: '{hex: 16'h8888, dp: 4'h0, blank: 4'h0, err: 4'h0}, perr: 8'd0};
    vecs[4] = '{segs: {7'h02, 7'h12, 7'h19, 7'h24}, dpn: 4'hF,
                exp: '{hex: 16'h6542, dp: 4'h0, blank: 4'h0, err: 4'h0}, perr: 8'd0};
    vecs[5] = '{segs: {7'h46, 7'h03, 7'h10, 7'h78}, dpn: 4'hF,
                exp: '{hex: 16'hCB97, dp: 4'h0, blank: 4'h0, err: 4'h0}, perr: 8'd0};
    vecs[6] = '{segs: {7'h79, 7'h0E, 7'h06, 7'h21}, dpn: 4'b0110,
                exp: '{hex: 16'h1FED, dp: 4'b1001, blank: 4'h0, err: 4'h0}, perr: 8'd0};

    bus.an_n  = 4'hF;
    bus.seg_n = 7'h7F;
    bus.dp_n  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset_frame_valid", 32'(bus.frame_valid), 32'h0);
    chk("reset_pattern_err", 32'(bus.pattern_err), 32'h0);
    @(posedge clk);
    #1;

    foreach (vecs[v]) begin
      exp_q.push_back(vecs[v].exp);
      f0 = frames;
      p0 = perrs;
      for (int d = 0; d < 4; d++) drive(d, vecs[v].segs[7*d +: 7], vecs[v].dpn[d], 40);
      idle(5);
      chk("vec_frame_count", 32'(frames - f0), 32'd1);
      chk("vec_pattern_err_count", 32'(perrs - p0), 32'(vecs[v].perr));
    end

    // Digits 1..3 captured, then digit 0 glitches faster than the settle window.
    drive(1, 7'h79, 1'b1, 40);
    drive(2, 7'h24, 1'b1, 40);
    drive(3, 7'h30, 1'b1, 40);
    f0 = frames;
    for (int k = 0; k < 9; k++) drive(0, (k % 2 == 0) ? 7'h12 : 7'h40, 1'b1, 10);
    chk("glitch_no_frame", 32'(frames - f0), 32'd0);
    ef = '{hex: 16'h3210, dp: 4'h0, blank: 4'h0, err: 4'h0};
    exp_q.push_back(ef);
    bus.seg_n = 7'h40;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.frame_valid) begin
        lat = c;
        break;
      end
    end
    chk("settle_latency", 32'(lat), 32'd19);
    @(posedge clk);
    #1;

    // Multiple-low and all-high anodes must not capture anything.
    f0 = frames;
    bus.an_n = 4'b0000;
    repeat (40) @(posedge clk);
    #1;
    idle(40);
    drive(1, 7'h40, 1'b1, 40);
    drive(2, 7'h40, 1'b1, 40);
    drive(3, 7'h40, 1'b1, 40);
    idle(5);
    chk("idle_no_frame", 32'(frames - f0), 32'd0);

    // Reset with three digits captured discards them.
    rst_n = 1'b0;
    #3;
    chk_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    f0 = frames;
    for (int d = 0; d < 3; d++) drive(d, 7'h00, 1'b1, 40);
    idle(5);
    chk("post_reset_no_frame", 32'(frames - f0), 32'd0);
    ef = '{hex: 16'h8888, dp: 4'h0, blank: 4'h0, err: 4'h0};
    exp_q.push_back(ef);
    f0 = frames;
    for (int d = 0; d < 4; d++) drive(d, 7'h00, 1'b1, 40);
    idle(5);
    chk("post_reset_frame", 32'(frames - f0), 32'd1);

    // Back-to-back scans: frames exactly one scan period apart.
    idle(10);
    exp_q.push_back(ef);
    exp_q.push_back(ef);
    f0 = frames;
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++) drive(d, 7'h00, 1'b1, 40);
    idle(5);
    chk("repeat_frame_count", 32'(frames - f0), 32'd2);
    chk("repeat_period", 32'(fv_time - fv_prev), 32'd160);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Readback counterpart of the team's hex-to-7-segment decoder: monitors a scanned 4-digit display (active-low segments plus DP, active-low digit anodes) and recovers each digit's hex value, DP, blank state and pattern validity.
- Publishes one atomic 4-digit frame after every digit has been captured.
- Sits on the board-test/self-check path, in parallel with the display pins.

Parameters:
- SETTLE_CYCLES, 16, consecutive identical synchronized samples required before a digit is captured (legal range 2..255).
- CNT_W, 8, settle counter width; must hold SETTLE_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- an_n  in  4  digit anodes, active-low; bit i selects digit i
- seg_n  in  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit)
- dp_n  in  1  decimal point, active-low
- hex_out  out  16  digit i nibble at [4i+3:4i]
- dp_out  out  4  bit i = DP lit on digit i
- blank_out  out  4  bit i = digit i had all seven segments dark (LE-style blank)
- err_out  out  4  bit i = digit i pattern not a legal hex glyph and not blank
- frame_valid  out  1  one-cycle pulse when the frame outputs update
- pattern_err  out  1  one-cycle pulse on every capture of an illegal pattern

Behaviour:
- Reset (async assert, sync release): all outputs 0; capture mask 0; FSM IDLE; synchronizers and shadow registers 0.
- Input path: an_n, seg_n and dp_n each pass through a 2-flop synchronizer. Sample S = {an_n, dp_n, seg_n} (12 bits) after synchronization. S_prev = S of the previous cycle.
- Legal glyphs, lit segments per hex digit:
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
  - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg; C adef; d bcdeg; E adefg; F aefg
  - seg_n = 7'h7F is blank. Blank: nibble 0, blank bit 1, err bit 0.
  - Any other pattern is illegal: nibble 0, err bit 1, pattern_err pulse.
- FSM, 3 states:
  - IDLE: entered when an_n does not have exactly one bit low. Counter cleared. Moves to SETTLE when exactly one bit is low.
  - SETTLE: counter increments each cycle while S == S_prev. Any change in S, or a one-hot loss, clears the counter (to SETTLE or IDLE respectively). When the counter reaches SETTLE_CYCLES-1 with S still stable, the capture happens that cycle and the FSM moves to HOLD.
  - HOLD: no further captures. Any change of S returns to SETTLE with counter 0, or to IDLE if an_n is no longer one-hot.
- Capture: decode into shadow slot idx (index of the low an_n bit) and set mask[idx]. Recapturing a slot before the frame completes overwrites the slot; the mask is unchanged.
- Frame: in the cycle after mask becomes 4'hF:
  - copy all shadow slots to hex_out/dp_out/blank_out/err_out together
  - pulse frame_valid
  - clear mask
  - A capture landing in that same cycle writes its shadow slot and sets its mask bit in the new, cleared mask.
- Latency: frame_valid fires 2 (sync) + SETTLE_CYCLES + 1 cycles after the final digit's inputs become stable at the pins.
- Outputs hold between frames. Reset mid-frame discards the shadow slots and mask; outputs return to 0.
- Counter saturates; it never wraps during a long HOLD.

Test Plan:
- Scan digits 0..3 with seg_n 7'h40, 7'h79, 7'h30, 7'h08 (dp_n=1), 40 cycles each -> single frame_valid; hex_out=16'hA310; dp_out=0; blank_out=0; err_out=0.
- Digit 2 with seg_n=7'h7F and dp_n=0, others 7'h40 -> hex_out=16'h0000; blank_out=4'b0100; dp_out=4'b0100; no pattern_err.
- Digit 1 with seg_n=7'h7E (only a lit) -> pattern_err pulses once; the following frame has err_out=4'b0010 and nibble 1 = 0.
- Glitch: toggle seg_n every 10 cycles with SETTLE_CYCLES=16 -> no capture and no frame_valid. Then hold stable -> capture exactly 2+16 cycles after the last change.
- an_n=4'b0000 (multiple low), then 4'b1111 -> FSM stays IDLE, mask stays 0. Also assert rst_n low after 3 digits captured -> all outputs 0, and 4 fresh digits are needed for the next frame.
- Full frame with all four digits lit as 8 (seg_n=7'h00) -> hex_out=16'h8888; then repeat the scan -> second frame_valid exactly one scan period later.
